// File: rtl/video_timing_gen_pkg.sv
// Shared constants for the raster timing generator: default 640x480 @ 25 MHz timing,
// counter width and sync polarity encodings, plus the sync-level helper.
package video_timing_pkg;

  localparam int DEF_COUNT_WIDTH   = 10;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_WIDTH  = 96;

  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_WIDTH  = 2;

  localparam bit SYNC_POL_LOW  = 1'b0;
  localparam bit SYNC_POL_HIGH = 1'b1;
  localparam bit DEF_SYNC_POL  = SYNC_POL_LOW;

  typedef struct packed {
    logic blank;
    logic sync;
  } axis_flags_t;

  // Converts "inside the sync window" into the pin level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input bit active_high);
    return active_high ? asserted : ~asserted;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle driven by video_timing_gen and consumed by downstream stages.
// o_Frame_Count exists only when VIDEO_TIMING_GEN_FRAME_CNT_EN is defined.
interface video_timing_if #(
  parameter int COUNT_WIDTH = video_timing_pkg::DEF_COUNT_WIDTH
);

  logic                   o_HSync;
  logic                   o_VSync;
  logic                   o_HBlank;
  logic                   o_VBlank;
  logic                   o_Active;
  logic [COUNT_WIDTH-1:0] o_Col_Count;
  logic [COUNT_WIDTH-1:0] o_Row_Count;
  logic                   o_Frame_Start;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  logic [7:0]             o_Frame_Count;
`endif

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  modport master (
    output o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active,
           o_Col_Count, o_Row_Count, o_Frame_Start, o_Frame_Count
  );
  modport slave (
    input  o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active,
           o_Col_Count, o_Row_Count, o_Frame_Start, o_Frame_Count
  );
`else
  modport master (
    output o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active,
           o_Col_Count, o_Row_Count, o_Frame_Start
  );
  modport slave (
    input  o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active,
           o_Col_Count, o_Row_Count, o_Frame_Start
  );
`endif

endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis: terminal-count position counter plus registered blank/sync decode.
// Flags are decoded from the next count so they line up with the registered count.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
  parameter int TOTAL            = DEF_TOTAL_COLS,
  parameter int ACTIVE           = DEF_ACTIVE_COLS,
  parameter int FRONT_PORCH      = DEF_H_FRONT_PORCH,
  parameter int SYNC_WIDTH       = DEF_H_SYNC_WIDTH,
  parameter bit SYNC_ACTIVE_HIGH = DEF_SYNC_POL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_advance,
  output logic                   o_terminal,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_blank,
  output logic                   o_sync,
  output logic                   o_active_next
);

  // One extra bit so a window ending exactly at 2**COUNT_WIDTH still compares correctly.
  localparam int EW = COUNT_WIDTH + 1;

  localparam logic [COUNT_WIDTH-1:0] LAST         = COUNT_WIDTH'(TOTAL - 1);
  localparam logic [EW-1:0]          ACTIVE_E     = EW'(ACTIVE);
  localparam logic [EW-1:0]          SYNC_START_E = EW'(ACTIVE + FRONT_PORCH);
  localparam logic [EW-1:0]          SYNC_END_E   = EW'(ACTIVE + FRONT_PORCH + SYNC_WIDTH);

  localparam axis_flags_t RESET_FLAGS = '{blank: 1'b0, sync: sync_level(1'b0, SYNC_ACTIVE_HIGH)};

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [EW-1:0]          count_e;
  axis_flags_t            flags_q, flags_d;

  assign o_terminal = (count_q == LAST);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (i_advance) begin
      count_d = o_terminal ? '0 : count_q + COUNT_WIDTH'(1);
    end
    count_e       = {1'b0, count_d};
    flags_d.blank = (count_e >= ACTIVE_E);
    flags_d.sync  = sync_level((count_e >= SYNC_START_E) && (count_e < SYNC_END_E),
                               SYNC_ACTIVE_HIGH);
  end

  assign o_active_next = ~flags_d.blank;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset restores position (0,0) with its decoded flags, i.e. a valid raster point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      flags_q <= RESET_FLAGS;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign o_count = count_q;
  assign o_blank = flags_q.blank;
  assign o_sync  = flags_q.sync;

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing source (HSync/VSync/blanks/active/position/frame strobe).
// Define VIDEO_TIMING_GEN_FRAME_CNT_EN to add the 8-bit o_Frame_Count output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
  parameter int TOTAL_COLS       = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS       = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH    = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH     = DEF_H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH    = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH     = DEF_V_SYNC_WIDTH,
  parameter bit SYNC_ACTIVE_HIGH = DEF_SYNC_POL
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_Enable,
  video_timing_if.master vid
);

  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h_timing
    $error("video_timing_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v_timing
    $error("video_timing_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
  end
  if ((TOTAL_COLS > 2**COUNT_WIDTH) || (TOTAL_ROWS > 2**COUNT_WIDTH)) begin : g_bad_width
    $error("video_timing_gen: COUNT_WIDTH too small for TOTAL_COLS/TOTAL_ROWS");
  end
  if ((H_SYNC_WIDTH < 1) || (V_SYNC_WIDTH < 1)) begin : g_bad_sync
    $error("video_timing_gen: sync widths must be at least 1");
  end

  logic                   h_terminal, v_terminal, v_advance;
  logic                   h_active_next, v_active_next;
  logic                   h_blank, v_blank, h_sync, v_sync;
  logic [COUNT_WIDTH-1:0] col, row;

  // The row only moves on the column wrap, so VSync and VBlank change at line boundaries.
  assign v_advance = i_Enable & h_terminal;

  video_timing_axis #(
    .COUNT_WIDTH      (COUNT_WIDTH),
    .TOTAL            (TOTAL_COLS),
    .ACTIVE           (ACTIVE_COLS),
    .FRONT_PORCH      (H_FRONT_PORCH),
    .SYNC_WIDTH       (H_SYNC_WIDTH),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_h_axis (
    .clk           (i_Clk),
    .rst_n         (i_Rst_n),
    .i_advance     (i_Enable),
    .o_terminal    (h_terminal),
    .o_count       (col),
    .o_blank       (h_blank),
    .o_sync        (h_sync),
    .o_active_next (h_active_next)
  );

  video_timing_axis #(
    .COUNT_WIDTH      (COUNT_WIDTH),
    .TOTAL            (TOTAL_ROWS),
    .ACTIVE           (ACTIVE_ROWS),
    .FRONT_PORCH      (V_FRONT_PORCH),
    .SYNC_WIDTH       (V_SYNC_WIDTH),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_v_axis (
    .clk           (i_Clk),
    .rst_n         (i_Rst_n),
    .i_advance     (v_advance),
    .o_terminal    (v_terminal),
    .o_count       (row),
    .o_blank       (v_blank),
    .o_sync        (v_sync),
    .o_active_next (v_active_next)
  );

  logic active_q, active_d;
  logic frame_start_q, frame_start_d;

  // Frame start marks the step from the last pixel of the frame to (0,0); disable blocks it.
  always_comb begin
    active_d      = h_active_next & v_active_next;
    frame_start_d = v_advance & v_terminal;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      active_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frame_count_q <= 8'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign vid.o_Frame_Count = frame_count_q;
`endif

  assign vid.o_HSync       = h_sync;
  assign vid.o_VSync       = v_sync;
  assign vid.o_HBlank      = h_blank;
  assign vid.o_VBlank      = v_blank;
  assign vid.o_Active      = active_q;
  assign vid.o_Col_Count   = col;
  assign vid.o_Row_Count   = row;
  assign vid.o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: default 640x480 timing, a 20x525 raster for the
// vertical/frame behaviour, and an 8x4 active-high raster for polarity and frame-count wrap.
module tb_video_timing_gen;

  localparam int B_TC = 20, B_TR = 525, B_AC = 12, B_HFP = 2, B_HSW = 3;
  localparam int B_AR = 480, B_VFP = 10, B_VSW = 2;
  localparam int C_TC = 8, C_TR = 4, C_AC = 6, C_HFP = 1, C_HSW = 1;
  localparam int C_AR = 3, C_VFP = 0, C_VSW = 1;

  typedef struct packed {
    logic       hs, vs, hb, vb, act, fs;
    logic [9:0] col, row;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int tc, tr, ac, hfp, hsw, ar, vfp, vsw;
    bit pol;
  } tim_t;

  typedef struct {
    int   k;
    obs_t e;
  } sb_t;

  logic clk;
  logic rst_n [3];
  logic en    [3];

  video_timing_if #(.COUNT_WIDTH(10)) vif_a ();
  video_timing_if #(.COUNT_WIDTH(10)) vif_b ();
  video_timing_if #(.COUNT_WIDTH(3))  vif_c ();

  video_timing_gen u_dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n[0]), .i_Enable(en[0]), .vid(vif_a)
  );

  video_timing_gen #(
    .COUNT_WIDTH(10), .TOTAL_COLS(B_TC), .TOTAL_ROWS(B_TR), .ACTIVE_COLS(B_AC),
    .ACTIVE_ROWS(B_AR), .H_FRONT_PORCH(B_HFP), .H_SYNC_WIDTH(B_HSW),
    .V_FRONT_PORCH(B_VFP), .V_SYNC_WIDTH(B_VSW), .SYNC_ACTIVE_HIGH(1'b0)
  ) u_dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n[1]), .i_Enable(en[1]), .vid(vif_b)
  );

  video_timing_gen #(
    .COUNT_WIDTH(3), .TOTAL_COLS(C_TC), .TOTAL_ROWS(C_TR), .ACTIVE_COLS(C_AC),
    .ACTIVE_ROWS(C_AR), .H_FRONT_PORCH(C_HFP), .H_SYNC_WIDTH(C_HSW),
    .V_FRONT_PORCH(C_VFP), .V_SYNC_WIDTH(C_VSW), .SYNC_ACTIVE_HIGH(1'b1)
  ) u_dut_c (
    .i_Clk(clk), .i_Rst_n(rst_n[2]), .i_Enable(en[2]), .vid(vif_c)
  );

  obs_t obs_a, obs_b, obs_c;
  logic [7:0] fc_a, fc_b, fc_c;

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  assign fc_a = vif_a.o_Frame_Count;
  assign fc_b = vif_b.o_Frame_Count;
  assign fc_c = vif_c.o_Frame_Count;
`else
  assign fc_a = 8'd0;
  assign fc_b = 8'd0;
  assign fc_c = 8'd0;
`endif

  assign obs_a = '{hs: vif_a.o_HSync, vs: vif_a.o_VSync, hb: vif_a.o_HBlank,
                   vb: vif_a.o_VBlank, act: vif_a.o_Active, fs: vif_a.o_Frame_Start,
                   col: vif_a.o_Col_Count, row: vif_a.o_Row_Count, fc: fc_a};
  assign obs_b = '{hs: vif_b.o_HSync, vs: vif_b.o_VSync, hb: vif_b.o_HBlank,
                   vb: vif_b.o_VBlank, act: vif_b.o_Active, fs: vif_b.o_Frame_Start,
                   col: vif_b.o_Col_Count, row: vif_b.o_Row_Count, fc: fc_b};
  assign obs_c = '{hs: vif_c.o_HSync, vs: vif_c.o_VSync, hb: vif_c.o_HBlank,
                   vb: vif_c.o_VBlank, act: vif_c.o_Active, fs: vif_c.o_Frame_Start,
                   col: 10'(vif_c.o_Col_Count), row: 10'(vif_c.o_Row_Count), fc: fc_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  sb_t sb_q [$];
  int  m_col [3];
  int  m_row [3];
  int  m_fc  [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic tim_t tim(input int k);
    tim_t t;
    case (k)
      0:       t = '{800, 525, 640, 16, 96, 480, 10, 2, 1'b0};
      1:       t = '{B_TC, B_TR, B_AC, B_HFP, B_HSW, B_AR, B_VFP, B_VSW, 1'b0};
      default: t = '{C_TC, C_TR, C_AC, C_HFP, C_HSW, C_AR, C_VFP, C_VSW, 1'b1};
    endcase
    return t;
  endfunction

  function automatic obs_t model(input int k, input int col, input int row,
                                 input bit fs, input int fc);
    tim_t t = tim(k);
    obs_t e;
    bit   hs_on, vs_on;
    hs_on = (col >= t.ac + t.hfp) && (col < t.ac + t.hfp + t.hsw);
    vs_on = (row >= t.ar + t.vfp) && (row < t.ar + t.vfp + t.vsw);
    e.hs  = t.pol ? hs_on : !hs_on;
    e.vs  = t.pol ? vs_on : !vs_on;
    e.hb  = (col >= t.ac);
    e.vb  = (row >= t.ar);
    e.act = !e.hb && !e.vb;
    e.fs  = fs;
    e.col = 10'(col);
    e.row = 10'(row);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    e.fc  = 8'(fc);
`else
    e.fc  = 8'd0;
`endif
    return e;
  endfunction

  function automatic obs_t pick(input int k);
    case (k)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  // Drive enable for one clock, push the predicted outputs, then compare after the edge.
  task automatic tick(input int k, input bit en_val);
    tim_t t = tim(k);
    bit   fs = 1'b0;
    sb_t  s;
    en[k] = en_val;
    if (en_val) begin
      fs = (m_col[k] == t.tc - 1) && (m_row[k] == t.tr - 1);
      if (m_col[k] == t.tc - 1) begin
        m_col[k] = 0;
        m_row[k] = (m_row[k] == t.tr - 1) ? 0 : m_row[k] + 1;
      end else begin
        m_col[k] = m_col[k] + 1;
      end
      if (fs) m_fc[k] = (m_fc[k] + 1) % 256;
    end
    sb_q.push_back('{k: k, e: model(k, m_col[k], m_row[k], fs, m_fc[k])});
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    check($sformatf("dut%0d_raster", s.k), pick(s.k), s.e);
  endtask

  // Asynchronous reset pulse starting away from any clock edge, held for three edges.
  task automatic pulse_reset(input int k);
    rst_n[k] = 1'b0;
    #2;
    check($sformatf("dut%0d_async_rst", k), pick(k), model(k, 0, 0, 1'b0, 0));
    m_col[k] = 0;
    m_row[k] = 0;
    m_fc[k]  = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check($sformatf("dut%0d_rst_hold", k), pick(k), model(k, 0, 0, 1'b0, 0));
    end
    rst_n[k] = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    obs_t o, e;
    int   first_hb, first_hs, hs_low, fs_cnt, fs_tick, frames, hs_hi, vs_hi;
    int   vb_rows, first_vb, vs_rows, first_vs;

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      en[k]    = 1'b0;
      m_col[k] = 0;
      m_row[k] = 0;
      m_fc[k]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;

    e = '0; e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b1;
    check("rst_state_a", obs_a, e);
    check("rst_state_b", obs_b, e);
    e = '0; e.act = 1'b1;
    check("rst_state_c_high_pol", obs_c, e);

    // Default timing: one full line, then a 37-cycle hold mid-line.
    en[0] = 1'b1;
    rst_n[0] = 1'b1;
    #2;
    check("release_a_pos", obs_a, model(0, 0, 0, 1'b0, 0));
    first_hb = -1; first_hs = -1; hs_low = 0;
    for (int i = 1; i <= 800; i++) begin
      tick(0, 1'b1);
      o = obs_a;
      if (o.row == 10'd0) begin
        if (o.hb && first_hb < 0) first_hb = int'(o.col);
        if (!o.hs) begin
          hs_low++;
          if (first_hs < 0) first_hs = int'(o.col);
        end
      end
    end
    check("hblank_first_col", 64'(first_hb), 64'd640);
    check("hsync_first_col", 64'(first_hs), 64'd656);
    check("hsync_len", 64'(hs_low), 64'd96);
    check("line_wrap_col", 64'(obs_a.col), 64'd0);
    check("line_wrap_row", 64'(obs_a.row), 64'd1);
    repeat (300) tick(0, 1'b1);
    check("hold_start_col", 64'(obs_a.col), 64'd300);
    fs_cnt = 0;
    repeat (37) begin
      tick(0, 1'b0);
      if (obs_a.fs) fs_cnt++;
    end
    check("hold_col", 64'(obs_a.col), 64'd300);
    check("hold_no_fs", 64'(fs_cnt), 64'd0);
    tick(0, 1'b1);
    check("resume_col", 64'(obs_a.col), 64'd301);
    en[0] = 1'b0;

    // 20x525 raster: vertical decode, frame strobe, period, mid-frame reset.
    en[1] = 1'b1;
    rst_n[1] = 1'b1;
    vb_rows = 0; first_vb = -1; vs_rows = 0; first_vs = -1; fs_cnt = 0; fs_tick = -1;
    for (int i = 1; i <= B_TC * B_TR; i++) begin
      tick(1, 1'b1);
      o = obs_b;
      if (o.col == 10'd0) begin
        if (o.vb) begin
          vb_rows++;
          if (first_vb < 0) first_vb = int'(o.row);
        end
        if (!o.vs) begin
          vs_rows++;
          if (first_vs < 0) first_vs = int'(o.row);
        end
      end
      if (o.fs) begin
        fs_cnt++;
        fs_tick = i;
        check("fs_at_origin", {o.col, o.row}, 64'd0);
      end
    end
    check("vblank_rows", 64'(vb_rows), 64'd45);
    check("vblank_first_row", 64'(first_vb), 64'd480);
    check("vsync_rows", 64'(vs_rows), 64'd2);
    check("vsync_first_row", 64'(first_vs), 64'd490);
    check("fs_count_f1", 64'(fs_cnt), 64'd1);
    check("fs_tick_f1", 64'(fs_tick), 64'd10500);
    fs_cnt = 0; fs_tick = -1;
    for (int i = 1; i <= B_TC * B_TR; i++) begin
      tick(1, 1'b1);
      if (obs_b.fs) begin
        fs_cnt++;
        fs_tick = i;
      end
    end
    check("fs_count_f2", 64'(fs_cnt), 64'd1);
    check("fs_period", 64'(fs_tick), 64'd10500);
    repeat (500 * B_TC + 15) tick(1, 1'b1);
    check("mid_frame_pos", {obs_b.col, obs_b.row}, {10'd15, 10'd500});
    pulse_reset(1);
    fs_cnt = 0; fs_tick = -1;
    for (int i = 1; i <= B_TC * B_TR; i++) begin
      tick(1, 1'b1);
      if (obs_b.fs) begin
        fs_cnt++;
        if (fs_tick < 0) fs_tick = i;
      end
    end
    check("fs_after_rst_count", 64'(fs_cnt), 64'd1);
    check("fs_after_rst_tick", 64'(fs_tick), 64'd10500);
    en[1] = 1'b0;

    // 8x4 active-high raster: sync polarity, hold on the frame boundary, count wrap.
    en[2] = 1'b1;
    rst_n[2] = 1'b1;
    frames = 0; hs_hi = 0; vs_hi = 0; fs_cnt = 0;
    for (int i = 1; i <= 256 * C_TC * C_TR; i++) begin
      tick(2, 1'b1);
      o = obs_c;
      if (i <= C_TC * C_TR) begin
        if (o.hs) begin
          hs_hi++;
          check("hs_high_col", 64'(o.col), 64'd7);
        end
        if (o.vs) vs_hi++;
      end
      if (o.fs) begin
        frames++;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        check("frame_count", 64'(o.fc), 64'(frames % 256));
`endif
      end
      if (i == C_TC * C_TR - 1) begin
        repeat (4) begin
          tick(2, 1'b0);
          if (obs_c.fs) fs_cnt++;
        end
        check("hold_at_last_pos", {obs_c.col, obs_c.row}, {10'd7, 10'd3});
      end
    end
    check("hs_high_cycles", 64'(hs_hi), 64'd4);
    check("vs_high_cycles", 64'(vs_hi), 64'd8);
    check("hold_c_no_fs", 64'(fs_cnt), 64'd0);
    check("frames_seen", 64'(frames), 64'd256);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    check("frame_count_wrapped", 64'(obs_c.fc), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
